// File: rtl/ws2812_strand_driver.sv
// WS2812 strand driver: requests per-LED GRB colours, serialises them MSB first
// as high/low pulse pairs, and closes every frame with a low latch gap.
module ws2812_strand_driver #(
   parameter int NUM_LEDS          = 50,
   parameter int LED_ADDRESS_WIDTH = 6,
   parameter int COLOR_LATENCY     = 2,
   parameter int T0H_CYCLES        = 35,
   parameter int T0L_CYCLES        = 80,
   parameter int T1H_CYCLES        = 70,
   parameter int T1L_CYCLES        = 55,
   parameter int RESET_CYCLES      = 28000
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
   input  logic [7:0]                   green_in,
   input  logic [7:0]                   red_in,
   input  logic [7:0]                   blue_in,
   input  logic                         color_valid,
   output logic                         strand_out,
   output logic                         busy,
   output logic                         frame_done
);
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXT = max2(max2(max2(T0H_CYCLES, T0L_CYCLES), max2(T1H_CYCLES, T1L_CYCLES)),
                              RESET_CYCLES);
   localparam int TW = $clog2(MAXT) + 1;
   localparam int LW = $clog2(COLOR_LATENCY + 1) + 1;
   localparam int AW = LED_ADDRESS_WIDTH;

   localparam logic [TW-1:0] RST_END = TW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0] T0H_END = TW'(T0H_CYCLES - 1);
   localparam logic [TW-1:0] T0L_END = TW'(T0L_CYCLES - 1);
   localparam logic [TW-1:0] T1H_END = TW'(T1H_CYCLES - 1);
   localparam logic [TW-1:0] T1L_END = TW'(T1L_CYCLES - 1);
   localparam logic [LW-1:0] LAT     = LW'(COLOR_LATENCY);
   localparam logic [AW-1:0] LAST    = AW'(NUM_LEDS - 1);

   typedef enum logic [2:0] {RESET_GAP, FETCH, LOAD, SEND_HIGH, SEND_LOW} state_t;

   state_t        state, state_nx;
   logic [TW-1:0] timer;
   logic [23:0]   shreg;
   logic [4:0]    bit_cnt;
   logic [AW-1:0] led_idx, req_nx;
   logic [LW-1:0] lat;
   logic          timer_done, last_led, last_bit;

   assign last_led = (led_idx == LAST);
   assign last_bit = (bit_cnt == 5'd23);

   always_comb begin
      state_nx   = state;
      req_nx     = next_led_request;
      timer_done = 1'b0;
      strand_out = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         RESET_GAP: begin
            timer_done = (timer == RST_END);
            frame_done = timer_done;
            if (timer_done) state_nx = FETCH;
         end
         FETCH: begin
            if (lat >= LAT && color_valid) state_nx = LOAD;
         end
         LOAD: begin
            busy     = 1'b1;
            // prefetch the next colour while this LED is being shifted out
            req_nx   = last_led ? '0 : led_idx + AW'(1);
            state_nx = SEND_HIGH;
         end
         SEND_HIGH: begin
            busy       = 1'b1;
            strand_out = 1'b1;
            timer_done = (timer == (shreg[23] ? T1H_END : T0H_END));
            if (timer_done) state_nx = SEND_LOW;
         end
         SEND_LOW: begin
            busy       = 1'b1;
            timer_done = (timer == (shreg[23] ? T1L_END : T0L_END));
            if (timer_done) begin
               if (!last_bit)     state_nx = SEND_HIGH;
               else if (last_led) state_nx = RESET_GAP;
               else               state_nx = FETCH;
            end
         end
         default: state_nx = RESET_GAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= RESET_GAP;
         timer            <= '0;
         shreg            <= '0;
         bit_cnt          <= '0;
         led_idx          <= '0;
         next_led_request <= '0;
         lat              <= '0;
      end else begin
         state            <= state_nx;
         next_led_request <= req_nx;

         if (req_nx != next_led_request) lat <= '0;
         else if (lat < LAT)             lat <= lat + LW'(1);

         // timer only runs in the timed states and restarts on every transition
         if (state_nx != state || state == FETCH || state == LOAD) timer <= '0;
         else                                                     timer <= timer + TW'(1);

         if (state == LOAD) begin
            shreg   <= {green_in, red_in, blue_in};
            bit_cnt <= '0;
         end else if (state == SEND_LOW && timer_done) begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (last_bit) led_idx <= last_led ? '0 : led_idx + AW'(1);
         end
      end
   end
endmodule

// File: tb/tb_ws2812_strand_driver.sv
// Directed bench for ws2812_strand_driver on a 3-LED strand with short timings;
// each frame is recorded cycle by cycle and pulse widths are checked against GRB words.
module tb_ws2812_strand_driver;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] next_led_request;
   logic [7:0] green_in, red_in, blue_in;
   logic       color_valid;
   logic       strand_out, busy, frame_done;

   int vec  = 0;
   int errs = 0;

   // colour source contents, also the expected serialised words
   logic [23:0] src [0:2];

   // frame recording
   int         ph [0:127];
   int         pl [0:127];
   int         np, fcyc, nchg, bad_chg, idle_cyc;
   logic [1:0] reqseq [0:15];
   int         stall_led;
   bit         toggle_mode;
   int         abort_at;
   bit         aborted;

   ws2812_strand_driver #(
      .NUM_LEDS(3), .LED_ADDRESS_WIDTH(2), .COLOR_LATENCY(2),
      .T0H_CYCLES(2), .T0L_CYCLES(4), .T1H_CYCLES(4), .T1L_CYCLES(2),
      .RESET_CYCLES(10)
   ) dut (
      .clk(clk), .rst(rst), .next_led_request(next_led_request),
      .green_in(green_in), .red_in(red_in), .blue_in(blue_in),
      .color_valid(color_valid), .strand_out(strand_out),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // counts cycles from reset release (that cycle is 1) up to the frame_done cycle
   task automatic wait_frame_done(output int n, output int hi);
      n  = 1;
      hi = (strand_out === 1'b1) ? 1 : 0;
      while (frame_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
         if (strand_out === 1'b1) hi++;
      end
   endtask

   // records one frame starting from a frame_done cycle, acting as the colour source
   task automatic capture_frame();
      bit         in_high = 0, in_low = 0, was_load = 0, tog = 0;
      int         stall_left = 0, load_cnt = 0;
      bit         stall_done = 0;
      logic [1:0] prev_req;
      np = 0; fcyc = 0; nchg = 0; bad_chg = 0; idle_cyc = 0; aborted = 0;
      prev_req = next_led_request;
      do begin
         @(negedge clk);
         fcyc++;
         if (next_led_request !== prev_req) begin
            if (!was_load) bad_chg++;
            if (nchg < 16) reqseq[nchg] = next_led_request;
            nchg++;
            prev_req = next_led_request;
         end
         was_load = 0;
         if (strand_out === 1'b1) begin
            if (!in_high) begin
               if (np < 128) begin ph[np] = 0; pl[np] = 0; end
               np++;
            end
            in_high = 1;
            in_low  = 1;
            if (np <= 128) ph[np-1]++;
            if (np - 1 == abort_at) begin
               rst     = 1'b1;
               aborted = 1;
               break;
            end
         end else begin
            in_high = 0;
            if (busy === 1'b1 && in_low) begin
               if (np <= 128) pl[np-1]++;
            end else if (busy === 1'b1) begin
               was_load = 1;
               load_cnt++;
            end else begin
               in_low = 0;
               idle_cyc++;
            end
         end
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) color_valid = 1'b1;
         end else if (!stall_done && busy === 1'b0 && np > 0 && next_led_request == 2'(stall_led)) begin
            color_valid = 1'b0;
            stall_left  = 20;
            stall_done  = 1;
         end
         if (toggle_mode) begin
            tog = ~tog;
            if (was_load)
               {green_in, red_in, blue_in} = src[(load_cnt - 1) % 3];
            else
               {green_in, red_in, blue_in} = tog ? ~src[load_cnt % 3] : 24'h5A5A5A;
         end else if (next_led_request < 2'd3) begin
            {green_in, red_in, blue_in} = src[next_led_request];
         end
      end while (frame_done !== 1'b1 && fcyc < 5000);
   endtask

   function automatic int pulse_errs();
      int  e = 0;
      bit  b;
      for (int p = 0; p < 72; p++) begin
         b = src[p / 24][23 - (p % 24)];
         if (ph[p] != (b ? 4 : 2) || pl[p] != (b ? 2 : 4)) e++;
      end
      return e;
   endfunction

   task automatic test_reset();
      int n, hi;
      rst = 1'b1; color_valid = 1'b1;
      src[0] = 24'h0; src[1] = 24'h0; src[2] = 24'h0;
      {green_in, red_in, blue_in} = 24'h0;
      stall_led = -1; toggle_mode = 0; abort_at = -1;
      repeat (3) @(negedge clk);
      vec++; if (strand_out !== 1'b0) begin errs++; $display("FAIL reset_strand: got %b expected 0", strand_out); end
      vec++; if (next_led_request !== 2'd0) begin errs++; $display("FAIL reset_req: got %0d expected 0", next_led_request); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vec++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      rst = 1'b0;
      wait_frame_done(n, hi);
      vec++; if (n !== 10) begin errs++; $display("FAIL first_frame_done: got cycle %0d expected 10", n); end
      vec++; if (hi !== 0) begin errs++; $display("FAIL gap_low: got %0d high cycles expected 0", hi); end
   endtask

   task automatic test_zero_frame();
      int e;
      capture_frame();
      vec++; if (fcyc !== 448) begin errs++; $display("FAIL zero_period: got %0d expected 448", fcyc); end
      vec++; if (np !== 72) begin errs++; $display("FAIL zero_pulses: got %0d expected 72", np); end
      e = pulse_errs();
      vec++; if (e !== 0) begin errs++; $display("FAIL zero_bits: got %0d bad pulses expected 0 (p0 %0d/%0d)", e, ph[0], pl[0]); end
      vec++; if (nchg !== 3 || reqseq[0] !== 2'd1 || reqseq[1] !== 2'd2 || reqseq[2] !== 2'd0) begin
         errs++; $display("FAIL req_trace: got %0d changes %0d,%0d,%0d expected 3 changes 1,2,0", nchg, reqseq[0], reqseq[1], reqseq[2]); end
      vec++; if (bad_chg !== 0) begin errs++; $display("FAIL req_at_load: got %0d changes outside LOAD expected 0", bad_chg); end
      vec++; if (idle_cyc !== 13) begin errs++; $display("FAIL idle_cycles: got %0d expected 13", idle_cyc); end
      vec++; if (next_led_request !== 2'd0) begin errs++; $display("FAIL req_in_gap: got %0d expected 0", next_led_request); end
   endtask

   task automatic test_pattern();
      int e;
      src[0] = 24'h800001; src[1] = 24'h800001; src[2] = 24'h800001;
      capture_frame();
      vec++; if (ph[0] !== 4 || pl[0] !== 2) begin errs++; $display("FAIL pat_first: got %0d/%0d expected 4/2", ph[0], pl[0]); end
      vec++; if (ph[23] !== 4 || pl[23] !== 2) begin errs++; $display("FAIL pat_last: got %0d/%0d expected 4/2", ph[23], pl[23]); end
      e = pulse_errs();
      vec++; if (e !== 0 || np !== 72) begin errs++; $display("FAIL pat_bits: got %0d bad of %0d pulses expected 0 of 72", e, np); end
      vec++; if (fcyc !== 10 + 3 * (2 + 2 * 6 + 22 * 6)) begin errs++; $display("FAIL pat_period: got %0d expected 448", fcyc); end
   endtask

   task automatic test_stall();
      int e;
      src[0] = 24'hF00F5A; src[1] = 24'h5AA5C3; src[2] = 24'h0180FF;
      stall_led = 1;
      capture_frame();
      stall_led = -1;
      vec++; if (fcyc !== 468) begin errs++; $display("FAIL stall_period: got %0d expected 468", fcyc); end
      vec++; if (idle_cyc !== 33) begin errs++; $display("FAIL stall_idle: got %0d expected 33", idle_cyc); end
      e = pulse_errs();
      vec++; if (e !== 0 || np !== 72) begin errs++; $display("FAIL stall_bits: got %0d bad of %0d pulses expected 0 of 72", e, np); end
      vec++; if (bad_chg !== 0 || nchg !== 3) begin errs++; $display("FAIL stall_req: got %0d stray of %0d changes expected 0 of 3", bad_chg, nchg); end
   endtask

   task automatic test_toggle();
      int e;
      src[0] = 24'hA53C0F; src[1] = 24'h123456; src[2] = 24'hFF0081;
      toggle_mode = 1;
      capture_frame();
      toggle_mode = 0;
      e = pulse_errs();
      vec++; if (e !== 0 || np !== 72) begin errs++; $display("FAIL toggle_bits: got %0d bad of %0d pulses expected 0 of 72", e, np); end
   endtask

   task automatic test_reset_mid_bit();
      int n, hi;
      src[0] = 24'h0; src[1] = 24'h0; src[2] = 24'h0;
      abort_at = 29;
      capture_frame();
      abort_at = -1;
      vec++; if (aborted !== 1'b1) begin errs++; $display("FAIL mid_abort_reached: got %b expected 1", aborted); end
      @(negedge clk);
      vec++; if (strand_out !== 1'b0) begin errs++; $display("FAIL mid_strand: got %b expected 0", strand_out); end
      vec++; if (next_led_request !== 2'd0) begin errs++; $display("FAIL mid_req: got %0d expected 0", next_led_request); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b expected 0", busy); end
      rst = 1'b0;
      wait_frame_done(n, hi);
      vec++; if (n !== 10 || hi !== 0) begin errs++; $display("FAIL mid_frame_done: got cycle %0d high %0d expected 10 and 0", n, hi); end
      capture_frame();
      vec++; if (fcyc !== 448 || np !== 72) begin errs++; $display("FAIL mid_restart: got %0d cycles %0d pulses expected 448 and 72", fcyc, np); end
   endtask

   initial begin
      test_reset();
      test_zero_frame();
      test_pattern();
      test_stall();
      test_toggle();
      test_reset_mid_bit();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
